// File: rtl/lfsr_engine.sv
// lfsr_engine: parametrised Galois/Fibonacci LFSR with free-run advance,
// seed loading with zero lock-up guard, and a counted burst mode.
//
// Handshake: burst_start/burst_len are sampled on an edge where the engine is
// idle and load is low. busy is high for the whole burst. done is a single-cycle
// pulse one cycle after the final advance, or one cycle after a zero-length
// request. A load or reset during a burst aborts it and suppresses done.
module lfsr_engine #(
    parameter int                WIDTH  = 16,
    parameter logic [WIDTH-1:0]  TAPS   = WIDTH'(16'h001D),
    parameter int                MODE   = 0,
    parameter int                INVERT = 0,
    parameter logic [WIDTH-1:0]  SEED   = '1,
    parameter int                CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              load,
    input  logic [WIDTH-1:0]  seed_in,
    input  logic              burst_start,
    input  logic [CNT_W-1:0]  burst_len,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  lfsr,
    output logic              out_bit,
    output logic              dbg_state
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic INV_B = (INVERT != 0);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_lfsr;
    logic               r_done;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [WIDTH-1:0]   w_lfsr_nxt;
    logic               w_done_nxt;

    logic               w_fb_gal;
    logic [WIDTH-1:0]   w_adv_gal;
    logic [WIDTH-1:0]   w_adv_fib;
    logic [WIDTH-1:0]   w_adv;
    logic [WIDTH-1:0]   w_load_val;

    // Single-step advance for both feedback structures; MODE picks one.
    always_comb begin
        w_fb_gal  = r_lfsr[WIDTH-1] ^ INV_B;
        w_adv_gal = {r_lfsr[WIDTH-2:0], 1'b0} ^ (w_fb_gal ? TAPS : '0);
        w_adv_fib = {r_lfsr[WIDTH-2:0], (^(r_lfsr & TAPS)) ^ INV_B};
        w_adv     = (MODE == 1) ? w_adv_fib : w_adv_gal;
    end

    // An all-zero seed would lock a plain XOR register forever, so fall back to SEED.
    always_comb begin
        w_load_val = seed_in;
        if ((seed_in == '0) && !INV_B) begin
            w_load_val = SEED;
        end
    end

    // Next-state logic: load beats burst activity, burst beats free-run enable.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lfsr_nxt  = r_lfsr;
        w_done_nxt  = 1'b0;
        if (load) begin
            w_lfsr_nxt  = w_load_val;
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (burst_start) begin
                        if (burst_len != '0) begin
                            w_cnt_nxt   = burst_len;
                            w_state_nxt = BURST;
                        end else begin
                            w_done_nxt  = 1'b1;
                        end
                    end else if (enable) begin
                        w_lfsr_nxt = w_adv;
                    end
                end
                BURST: begin
                    w_lfsr_nxt = w_adv;
                    w_cnt_nxt  = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // State registers; reset clears everything immediately, including any burst.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_lfsr  <= SEED;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign busy      = (r_state == BURST);
    assign done      = r_done;
    assign lfsr      = r_lfsr;
    assign out_bit   = r_lfsr[WIDTH-1];
    assign dbg_state = r_state;

endmodule

// File: tb/tb_lfsr_engine.sv
// Directed bench for lfsr_engine: a Galois instance (defaults) and a
// Fibonacci instance (MODE=1) share all inputs.
module tb_lfsr_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] seed_in = '0;
    logic        burst_start = 1'b0;
    logic [7:0]  burst_len = '0;

    logic        g_busy, g_done, g_out_bit, g_dbg;
    logic [15:0] g_lfsr;
    logic        f_busy, f_done, f_out_bit, f_dbg;
    logic [15:0] f_lfsr;

    int n_total = 0;
    int n_bad   = 0;

    lfsr_engine dut_g (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .seed_in(seed_in), .burst_start(burst_start), .burst_len(burst_len),
        .busy(g_busy), .done(g_done), .lfsr(g_lfsr), .out_bit(g_out_bit),
        .dbg_state(g_dbg)
    );

    lfsr_engine #(.MODE(1)) dut_f (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .seed_in(seed_in), .burst_start(burst_start), .burst_len(burst_len),
        .busy(f_busy), .done(f_done), .lfsr(f_lfsr), .out_bit(f_out_bit),
        .dbg_state(f_dbg)
    );

    // clock
    always #5 clk = ~clk;

    // Reference Fibonacci step for default taps 0x001D, no inversion.
    function automatic logic [15:0] fib_ref(input logic [15:0] v);
        logic [15:0] t;
        logic        b;
        t = v & 16'h001D;
        b = t[0] ^ t[2] ^ t[3] ^ t[4];
        return {v[14:0], b};
    endfunction

    task automatic apply_reset();
        enable = 0; load = 0; burst_start = 0; burst_len = 0; seed_in = 0;
        reset = 1;
        @(negedge clk);
        reset = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 reset = 1;
        #1;
        n_total++; if (g_lfsr !== 16'hFFFF) begin n_bad++; $display("FAIL reset_lfsr got=%h exp=%h", g_lfsr, 16'hFFFF); end
        n_total++; if (g_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", g_busy); end
        n_total++; if (g_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b exp=0", g_done); end
        n_total++; if (g_out_bit !== 1'b1) begin n_bad++; $display("FAIL reset_out_bit got=%b exp=1", g_out_bit); end
        n_total++; if (f_lfsr !== 16'hFFFF) begin n_bad++; $display("FAIL reset_fib_lfsr got=%h exp=%h", f_lfsr, 16'hFFFF); end
        @(negedge clk);
        @(negedge clk);
        n_total++; if (g_lfsr !== 16'hFFFF) begin n_bad++; $display("FAIL reset_held_lfsr got=%h exp=%h", g_lfsr, 16'hFFFF); end
        reset = 0;
        @(negedge clk);
    endtask

    task automatic test_galois_enable();
        apply_reset();
        enable = 1;
        @(negedge clk);
        n_total++; if (g_lfsr !== 16'hFFE3) begin n_bad++; $display("FAIL gal_step1 got=%h exp=%h", g_lfsr, 16'hFFE3); end
        @(negedge clk);
        n_total++; if (g_lfsr !== 16'hFFDB) begin n_bad++; $display("FAIL gal_step2 got=%h exp=%h", g_lfsr, 16'hFFDB); end
        enable = 0;
        @(negedge clk);
        n_total++; if (g_lfsr !== 16'hFFDB) begin n_bad++; $display("FAIL gal_hold got=%h exp=%h", g_lfsr, 16'hFFDB); end
    endtask

    task automatic test_fibonacci();
        logic [15:0] m;
        int          m_hits;
        int          d_hits;
        apply_reset();
        enable = 1;
        @(negedge clk);
        n_total++; if (f_lfsr !== 16'hFFFE) begin n_bad++; $display("FAIL fib_step1 got=%h exp=%h", f_lfsr, 16'hFFFE); end
        m = 16'hFFFE;
        m_hits = 0;
        d_hits = 0;
        for (int i = 2; i <= 65535; i++) begin
            @(negedge clk);
            m = fib_ref(m);
            if (m == 16'hFFFF) m_hits++;
            if (f_lfsr == 16'hFFFF) d_hits++;
            if ((i % 8192) == 0) begin
                n_total++;
                if (f_lfsr !== m) begin n_bad++; $display("FAIL fib_run_%0d got=%h exp=%h", i, f_lfsr, m); end
            end
        end
        enable = 0;
        n_total++; if (f_lfsr !== m) begin n_bad++; $display("FAIL fib_final got=%h exp=%h", f_lfsr, m); end
        n_total++; if (d_hits !== m_hits) begin n_bad++; $display("FAIL fib_seed_revisits got=%0d exp=%0d", d_hits, m_hits); end
    endtask

    task automatic test_load();
        apply_reset();
        load = 1; seed_in = 16'h1234;
        @(negedge clk);
        n_total++; if (g_lfsr !== 16'h1234) begin n_bad++; $display("FAIL load_1234 got=%h exp=%h", g_lfsr, 16'h1234); end
        seed_in = 16'h0000;
        @(negedge clk);
        n_total++; if (g_lfsr !== 16'hFFFF) begin n_bad++; $display("FAIL load_zero_guard got=%h exp=%h", g_lfsr, 16'hFFFF); end
        load = 0;
        enable = 1; load = 1; seed_in = 16'h0F0F;
        @(negedge clk);
        n_total++; if (g_lfsr !== 16'h0F0F) begin n_bad++; $display("FAIL load_over_enable got=%h exp=%h", g_lfsr, 16'h0F0F); end
        load = 0; enable = 0;
    endtask

    task automatic test_burst3();
        logic [15:0] exp_v [4];
        exp_v[0] = 16'hFFFF; exp_v[1] = 16'hFFE3; exp_v[2] = 16'hFFDB; exp_v[3] = 16'hFFAB;
        apply_reset();
        burst_start = 1; burst_len = 8'd3;
        @(negedge clk);
        burst_start = 0; burst_len = 8'd0;
        for (int k = 0; k < 3; k++) begin
            n_total++; if (g_busy !== 1'b1) begin n_bad++; $display("FAIL burst3_busy_%0d got=%b exp=1", k, g_busy); end
            n_total++; if (g_lfsr !== exp_v[k]) begin n_bad++; $display("FAIL burst3_lfsr_%0d got=%h exp=%h", k, g_lfsr, exp_v[k]); end
            n_total++; if (g_done !== 1'b0) begin n_bad++; $display("FAIL burst3_early_done_%0d got=%b exp=0", k, g_done); end
            enable = ~enable;
            @(negedge clk);
        end
        enable = 0;
        n_total++; if (g_busy !== 1'b0) begin n_bad++; $display("FAIL burst3_end_busy got=%b exp=0", g_busy); end
        n_total++; if (g_done !== 1'b1) begin n_bad++; $display("FAIL burst3_done got=%b exp=1", g_done); end
        n_total++; if (g_lfsr !== exp_v[3]) begin n_bad++; $display("FAIL burst3_final got=%h exp=%h", g_lfsr, exp_v[3]); end
        @(negedge clk);
        n_total++; if (g_done !== 1'b0) begin n_bad++; $display("FAIL burst3_done_clear got=%b exp=0", g_done); end
        n_total++; if (g_lfsr !== exp_v[3]) begin n_bad++; $display("FAIL burst3_hold got=%h exp=%h", g_lfsr, exp_v[3]); end
    endtask

    task automatic test_burst_zero();
        apply_reset();
        burst_start = 1; burst_len = 8'd0; enable = 1;
        @(negedge clk);
        burst_start = 0; enable = 0;
        n_total++; if (g_done !== 1'b1) begin n_bad++; $display("FAIL zero_done got=%b exp=1", g_done); end
        n_total++; if (g_busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy got=%b exp=0", g_busy); end
        n_total++; if (g_lfsr !== 16'hFFFF) begin n_bad++; $display("FAIL zero_lfsr got=%h exp=%h", g_lfsr, 16'hFFFF); end
        @(negedge clk);
        n_total++; if (g_done !== 1'b0) begin n_bad++; $display("FAIL zero_done_clear got=%b exp=0", g_done); end
        n_total++; if (g_busy !== 1'b0) begin n_bad++; $display("FAIL zero_busy_after got=%b exp=0", g_busy); end
    endtask

    task automatic test_burst_load_abort();
        apply_reset();
        burst_start = 1; burst_len = 8'd10;
        @(negedge clk);
        burst_start = 0;
        repeat (3) @(negedge clk);
        n_total++; if (g_lfsr !== 16'hFFAB) begin n_bad++; $display("FAIL abort_pre_load got=%h exp=%h", g_lfsr, 16'hFFAB); end
        load = 1; seed_in = 16'hA5A5;
        @(negedge clk);
        load = 0;
        n_total++; if (g_lfsr !== 16'hA5A5) begin n_bad++; $display("FAIL abort_load_lfsr got=%h exp=%h", g_lfsr, 16'hA5A5); end
        n_total++; if (g_busy !== 1'b0) begin n_bad++; $display("FAIL abort_load_busy got=%b exp=0", g_busy); end
        for (int k = 0; k < 12; k++) begin
            n_total++; if (g_done !== 1'b0) begin n_bad++; $display("FAIL abort_load_done_%0d got=%b exp=0", k, g_done); end
            @(negedge clk);
        end
        n_total++; if (g_lfsr !== 16'hA5A5) begin n_bad++; $display("FAIL abort_load_hold got=%h exp=%h", g_lfsr, 16'hA5A5); end
    endtask

    task automatic test_burst_reset_abort();
        apply_reset();
        burst_start = 1; burst_len = 8'd10;
        @(negedge clk);
        burst_start = 0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 reset = 1;
        #1;
        n_total++; if (g_lfsr !== 16'hFFFF) begin n_bad++; $display("FAIL abort_reset_lfsr got=%h exp=%h", g_lfsr, 16'hFFFF); end
        n_total++; if (g_busy !== 1'b0) begin n_bad++; $display("FAIL abort_reset_busy got=%b exp=0", g_busy); end
        @(negedge clk);
        reset = 0;
        for (int k = 0; k < 12; k++) begin
            n_total++; if ((g_done !== 1'b0) || (g_busy !== 1'b0)) begin
                n_bad++; $display("FAIL abort_reset_idle_%0d got=done%b/busy%b exp=0/0", k, g_done, g_busy);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        burst_start = 1; burst_len = 8'd2;
        @(negedge clk);
        burst_start = 0;
        @(negedge clk);
        @(negedge clk);
        n_total++; if (g_done !== 1'b1) begin n_bad++; $display("FAIL b2b_first_done got=%b exp=1", g_done); end
        n_total++; if (g_lfsr !== 16'hFFDB) begin n_bad++; $display("FAIL b2b_first_lfsr got=%h exp=%h", g_lfsr, 16'hFFDB); end
        burst_start = 1; burst_len = 8'd1;
        @(negedge clk);
        burst_start = 0;
        n_total++; if (g_busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept_busy got=%b exp=1", g_busy); end
        n_total++; if (g_done !== 1'b0) begin n_bad++; $display("FAIL b2b_accept_done got=%b exp=0", g_done); end
        @(negedge clk);
        n_total++; if (g_done !== 1'b1) begin n_bad++; $display("FAIL b2b_second_done got=%b exp=1", g_done); end
        n_total++; if (g_lfsr !== 16'hFFAB) begin n_bad++; $display("FAIL b2b_second_lfsr got=%h exp=%h", g_lfsr, 16'hFFAB); end
        n_total++; if (g_busy !== 1'b0) begin n_bad++; $display("FAIL b2b_second_busy got=%b exp=0", g_busy); end
    endtask

    initial begin
        test_reset();
        test_galois_enable();
        test_fibonacci();
        test_load();
        test_burst3();
        test_burst_zero();
        test_burst_load_abort();
        test_burst_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
